// File: rtl/fetch_unit_basic_pkg.sv
// Shared RV core package: ISA opcodes plus
// fetch-stage message types and defaults.
package fetch_unit_basic_pkg;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011
  } rv_opcode_t;

  localparam logic [31:0] RST_ADDR = 32'h0000_0200;
  localparam int MAX_IN_FLIGHT = 2;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_msg_t;

endpackage

// File: rtl/fetch_unit_basic_if.sv
// Fetch stage buses: memory request/response,
// decode handoff and squash/redirect.
interface fetch_unit_basic_if;
  logic        mem_req_val;
  logic        mem_req_rdy;
  logic [31:0] mem_req_addr;
  logic        mem_resp_val;
  logic        mem_resp_rdy;
  logic [31:0] mem_resp_data;
  logic        D_val;
  logic        D_rdy;
  logic [31:0] D_inst;
  logic [31:0] D_pc;
  logic        squash_val;
  logic [31:0] squash_target;

  modport master (
    output mem_req_val, mem_req_addr,
    input  mem_req_rdy,
    input  mem_resp_val, mem_resp_data,
    output mem_resp_rdy,
    output D_val, D_inst, D_pc,
    input  D_rdy,
    input  squash_val, squash_target
  );

  modport slave (
    input  mem_req_val, mem_req_addr,
    output mem_req_rdy,
    output mem_resp_val, mem_resp_data,
    input  mem_resp_rdy,
    input  D_val, D_inst, D_pc,
    output D_rdy,
    output squash_val, squash_target
  );
endinterface

// File: rtl/fetch_unit_basic_fifo.sv
// Depth-N synchronous FIFO with flush;
// used for the PC queue and response buffer.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_cnt;

  function automatic logic [AW-1:0] f_inc(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // pointer and occupancy update; flush wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wr <= f_inc(r_wr);
      if (i_pop)  r_rd <= f_inc(r_rd);
      r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
    end
  end

  // storage needs no reset; occupancy gates it
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr] <= i_data;
  end

  assign o_data  = r_mem[r_rd];
  assign o_count = r_cnt;
endmodule

// File: rtl/fetch_unit_basic.sv
// Fetch stage: PC, credit-limited memory requests,
// in-order response buffer and squash handling.
module fetch_unit_basic
  import fetch_unit_basic_pkg::*;
#(
  parameter logic [31:0] p_rst_addr      = RST_ADDR,
  parameter int          p_max_in_flight = MAX_IN_FLIGHT
) (
  input logic                 clk,
  input logic                 rst,
  fetch_unit_basic_if.master  bus
);
  localparam int CW = $clog2(p_max_in_flight + 1);

  logic [31:0]   r_pc;
  logic [CW-1:0] r_in_flight;
  logic [CW-1:0] r_drop;
  logic          r_run;

  logic [CW-1:0] w_if_nxt;
  logic [CW-1:0] w_drop_nxt;
  logic [CW-1:0] w_pcq_cnt;
  logic [CW-1:0] w_rsp_cnt;
  logic [31:0]   w_pcq_head;
  logic [31:0]   w_resp_pc;
  logic [CW+1:0] w_sum;
  logic          w_credit;
  logic          w_sq;
  logic          w_req_fire;
  logic          w_resp_fire;
  logic          w_resp_keep;
  logic          w_out_fire;
  logic          w_pcq_empty;
  logic          w_pcq_push;
  logic          w_pcq_pop;
  fetch_msg_t    w_push_msg;
  fetch_msg_t    w_head;

  assign w_sq  = bus.squash_val;
  assign w_sum = {2'b00, r_in_flight}
               + {2'b00, r_drop}
               + {2'b00, w_rsp_cnt};
  assign w_credit =
    w_sum < (CW+2)'(p_max_in_flight);

  assign bus.mem_req_val  = r_run & !w_sq & w_credit;
  assign bus.mem_req_addr = r_pc;
  assign bus.mem_resp_rdy = r_run;

  assign w_req_fire  = bus.mem_req_val
                     & bus.mem_req_rdy;
  assign w_resp_fire = bus.mem_resp_val & r_run;
  assign w_resp_keep = w_resp_fire
                     & (r_drop == '0) & !w_sq;

  // a response with an empty PC queue belongs to
  // the request firing this same cycle
  assign w_pcq_empty = (w_pcq_cnt == '0);
  assign w_resp_pc   = w_pcq_empty ? r_pc : w_pcq_head;
  assign w_pcq_push  = w_req_fire
                     & !(w_resp_keep & w_pcq_empty);
  assign w_pcq_pop   = w_resp_keep & !w_pcq_empty;

  assign w_push_msg.inst = bus.mem_resp_data;
  assign w_push_msg.pc   = w_resp_pc;

  assign bus.D_val  = (w_rsp_cnt != '0) & !w_sq;
  assign bus.D_inst = w_head.inst;
  assign bus.D_pc   = w_head.pc;
  assign w_out_fire = bus.D_val & bus.D_rdy;

  fetch_fifo #(
    .WIDTH (32),
    .DEPTH (p_max_in_flight)
  ) u_pcq (
    .clk     (clk),
    .rst_n   (rst),
    .i_flush (w_sq),
    .i_push  (w_pcq_push),
    .i_data  (r_pc),
    .i_pop   (w_pcq_pop),
    .o_data  (w_pcq_head),
    .o_count (w_pcq_cnt)
  );

  fetch_fifo #(
    .WIDTH ($bits(fetch_msg_t)),
    .DEPTH (p_max_in_flight)
  ) u_rspq (
    .clk     (clk),
    .rst_n   (rst),
    .i_flush (w_sq),
    .i_push  (w_resp_keep),
    .i_data  (w_push_msg),
    .i_pop   (w_out_fire),
    .o_data  (w_head),
    .o_count (w_rsp_cnt)
  );

  // in-flight and drop counters; squash moves
  // all outstanding requests into drop
  always_comb begin
    w_if_nxt   = r_in_flight;
    w_drop_nxt = r_drop;
    if (w_sq) begin
      w_if_nxt   = '0;
      w_drop_nxt = r_drop + r_in_flight
                 - CW'(w_resp_fire);
    end else begin
      if (w_resp_fire && r_drop != '0)
        w_drop_nxt = r_drop - 1'b1;
      w_if_nxt = r_in_flight + CW'(w_req_fire)
               - CW'(w_resp_keep);
    end
  end

  // PC, counters and run flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc        <= p_rst_addr;
      r_in_flight <= '0;
      r_drop      <= '0;
      r_run       <= 1'b0;
    end else begin
      r_run       <= 1'b1;
      r_in_flight <= w_if_nxt;
      r_drop      <= w_drop_nxt;
      if (w_sq)
        r_pc <= bus.squash_target & ~32'd3;
      else if (w_req_fire)
        r_pc <= r_pc + 32'd4;
    end
  end
endmodule

// File: tb/tb_fetch_unit_basic.sv
// Directed bench for fetch_unit_basic with a
// latency-configurable memory model.
module tb_fetch_unit_basic;
  logic clk;
  logic rst;
  int   lat;
  int   cyc;
  int   n_vec;
  int   n_err;
  logic        r_mv;
  logic [31:0] r_md;

  typedef struct {
    logic [31:0] a;
    int          due;
  } mreq_t;
  mreq_t mq[$];

  fetch_unit_basic_if bus();

  fetch_unit_basic #(
    .p_rst_addr      (32'h0000_0200),
    .p_max_in_flight (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] f_inst(
    input logic [31:0] a
  );
    return a ^ 32'hC0DE_0000;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_resp_val = (lat == 0)
    ? (bus.mem_req_val & bus.mem_req_rdy) : r_mv;
  assign bus.mem_resp_data = (lat == 0)
    ? f_inst(bus.mem_req_addr) : r_md;

  always @(posedge clk) begin
    if (!rst) begin
      mq.delete();
      r_mv = 1'b0;
      r_md = '0;
    end else begin
      if (lat > 0 && bus.mem_req_val
          && bus.mem_req_rdy)
        mq.push_back('{bus.mem_req_addr, cyc + lat});
      cyc++;
      #1;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        r_mv = 1'b1;
        r_md = f_inst(mq[0].a);
        void'(mq.pop_front());
      end else begin
        r_mv = 1'b0;
      end
    end
  end

  task automatic apply_reset(input int l,
                             input logic drdy);
    rst = 1'b0;
    lat = l;
    bus.D_rdy = drdy;
    bus.mem_req_rdy = 1'b1;
    bus.squash_val = 1'b0;
    bus.squash_target = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    lat = 0;
    bus.D_rdy = 1'b1;
    bus.mem_req_rdy = 1'b1;
    bus.squash_val = 1'b0;
    bus.squash_target = '0;
    repeat (3) begin
      @(negedge clk);
      n_vec++;
      if (bus.mem_req_val !== 1'b0) begin
        n_err++;
        $display("FAIL rst_req_val got %b want 0",
                 bus.mem_req_val);
      end
      n_vec++;
      if (bus.D_val !== 1'b0) begin
        n_err++;
        $display("FAIL rst_d_val got %b want 0",
                 bus.D_val);
      end
      n_vec++;
      if (bus.mem_resp_rdy !== 1'b0) begin
        n_err++;
        $display("FAIL rst_resp_rdy got %b want 0",
                 bus.mem_resp_rdy);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    n_vec++;
    if (bus.mem_resp_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL post_rst_rdy got %b want 1",
               bus.mem_resp_rdy);
    end
  endtask

  task automatic test_stream;
    apply_reset(0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      n_vec++;
      if (bus.mem_req_val !== 1'b1 ||
          bus.mem_req_addr !== 32'h200 + 4*k) begin
        n_err++;
        $display("FAIL stream_req k=%0d got %b/%h want 1/%h",
                 k, bus.mem_req_val, bus.mem_req_addr,
                 32'h200 + 4*k);
      end
      n_vec++;
      if (k == 0) begin
        if (bus.D_val !== 1'b0) begin
          n_err++;
          $display("FAIL stream_dval0 got %b want 0",
                   bus.D_val);
        end
      end else if (bus.D_val !== 1'b1 ||
          bus.D_pc !== 32'h200 + 4*(k-1) ||
          bus.D_inst !==
            f_inst(32'h200 + 4*(k-1))) begin
        n_err++;
        $display("FAIL stream_d k=%0d got %b/%h/%h want 1/%h",
                 k, bus.D_val, bus.D_pc, bus.D_inst,
                 32'h200 + 4*(k-1));
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] e_pc [3];
    e_pc[0] = 32'h200;
    e_pc[1] = 32'h204;
    e_pc[2] = 32'h208;
    apply_reset(0, 1'b0);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      bus.D_rdy = (k >= 4);
      #1;
      if (k < 2 || k >= 5) begin
        n_vec++;
        if (bus.mem_req_val !== 1'b1 ||
            bus.mem_req_addr !==
              (k < 2 ? 32'h200 + 4*k
                     : 32'h208 + 4*(k-5))) begin
          n_err++;
          $display("FAIL bp_req k=%0d got %b/%h",
                   k, bus.mem_req_val,
                   bus.mem_req_addr);
        end
      end else begin
        n_vec++;
        if (bus.mem_req_val !== 1'b0) begin
          n_err++;
          $display("FAIL bp_stall k=%0d got %b want 0",
                   k, bus.mem_req_val);
        end
      end
      if (k >= 2) begin
        n_vec++;
        if (bus.D_val !== 1'b1 ||
            bus.D_pc !== e_pc[k < 4 ? 0 : k-4]) begin
          n_err++;
          $display("FAIL bp_d k=%0d got %b/%h want 1/%h",
                   k, bus.D_val, bus.D_pc,
                   e_pc[k < 4 ? 0 : k-4]);
        end
      end
    end
  endtask

  task automatic test_squash_latency;
    apply_reset(3, 1'b1);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      bus.squash_val = (k == 2);
      bus.squash_target = 32'h1003;
      #1;
      if (k == 2 || k == 3) begin
        n_vec++;
        if (bus.mem_req_val !== 1'b0) begin
          n_err++;
          $display("FAIL sqlat_stall k=%0d got %b want 0",
                   k, bus.mem_req_val);
        end
      end
      if (k == 4) begin
        n_vec++;
        if (bus.mem_req_val !== 1'b1 ||
            bus.mem_req_addr !== 32'h1000) begin
          n_err++;
          $display("FAIL sqlat_req got %b/%h want 1/00001000",
                   bus.mem_req_val, bus.mem_req_addr);
        end
      end
      if (k < 8) begin
        n_vec++;
        if (bus.D_val !== 1'b0) begin
          n_err++;
          $display("FAIL sqlat_dval k=%0d got %b want 0",
                   k, bus.D_val);
        end
      end else begin
        n_vec++;
        if (bus.D_val !== 1'b1 ||
            bus.D_pc !== 32'h1000 ||
            bus.D_inst !== f_inst(32'h1000)) begin
          n_err++;
          $display("FAIL sqlat_d got %b/%h/%h want 1/00001000",
                   bus.D_val, bus.D_pc, bus.D_inst);
        end
      end
    end
    bus.squash_val = 1'b0;
  endtask

  task automatic test_squash_resp;
    apply_reset(3, 1'b1);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      bus.squash_val = (k == 3);
      bus.squash_target = 32'h2000;
      #1;
      if (k == 3) begin
        n_vec++;
        if (bus.mem_resp_val !== 1'b1) begin
          n_err++;
          $display("FAIL sqresp_arrive got %b want 1",
                   bus.mem_resp_val);
        end
      end
      if (k == 4) begin
        n_vec++;
        if (bus.mem_req_val !== 1'b1 ||
            bus.mem_req_addr !== 32'h2000) begin
          n_err++;
          $display("FAIL sqresp_req got %b/%h want 1/00002000",
                   bus.mem_req_val, bus.mem_req_addr);
        end
      end
      if (k >= 3 && k < 8) begin
        n_vec++;
        if (bus.D_val !== 1'b0) begin
          n_err++;
          $display("FAIL sqresp_dval k=%0d got %b want 0",
                   k, bus.D_val);
        end
      end
      if (k == 8) begin
        n_vec++;
        if (bus.D_val !== 1'b1 ||
            bus.D_pc !== 32'h2000) begin
          n_err++;
          $display("FAIL sqresp_d got %b/%h want 1/00002000",
                   bus.D_val, bus.D_pc);
        end
      end
    end
    bus.squash_val = 1'b0;
  endtask

  task automatic test_squash_flush;
    apply_reset(0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      bus.squash_val = (k == 3);
      bus.squash_target = 32'h300;
      #1;
      if (k == 3) begin
        n_vec++;
        if (bus.D_val !== 1'b0 ||
            bus.mem_req_val !== 1'b0) begin
          n_err++;
          $display("FAIL flush_sq got %b/%b want 0/0",
                   bus.D_val, bus.mem_req_val);
        end
      end
      if (k == 4) begin
        n_vec++;
        if (bus.D_val !== 1'b0 ||
            bus.mem_req_val !== 1'b1 ||
            bus.mem_req_addr !== 32'h300) begin
          n_err++;
          $display("FAIL flush_req got %b/%b/%h want 0/1/00000300",
                   bus.D_val, bus.mem_req_val,
                   bus.mem_req_addr);
        end
      end
      if (k == 5) begin
        n_vec++;
        if (bus.D_val !== 1'b1 ||
            bus.D_pc !== 32'h300) begin
          n_err++;
          $display("FAIL flush_d got %b/%h want 1/00000300",
                   bus.D_val, bus.D_pc);
        end
      end
    end
    bus.squash_val = 1'b0;
  endtask

  task automatic test_wrap;
    apply_reset(0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.squash_val = (k == 0);
      bus.squash_target = 32'hFFFF_FFFC;
      #1;
      if (k >= 1) begin
        n_vec++;
        if (bus.mem_req_val !== 1'b1 ||
            bus.mem_req_addr !==
              32'hFFFF_FFFC + 4*(k-1)) begin
          n_err++;
          $display("FAIL wrap_req k=%0d got %b/%h",
                   k, bus.mem_req_val,
                   bus.mem_req_addr);
        end
      end
      if (k >= 2) begin
        n_vec++;
        if (bus.D_val !== 1'b1 ||
            bus.D_pc !== 32'hFFFF_FFFC + 4*(k-2)) begin
          n_err++;
          $display("FAIL wrap_d k=%0d got %b/%h",
                   k, bus.D_val, bus.D_pc);
        end
      end
    end
    bus.squash_val = 1'b0;
  endtask

  task automatic test_reset_mid;
    apply_reset(0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1;
    n_vec++;
    if (bus.D_val !== 1'b1 ||
        bus.mem_req_val !== 1'b1) begin
      n_err++;
      $display("FAIL rmid_pre got %b/%b want 1/1",
               bus.D_val, bus.mem_req_val);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (bus.D_val !== 1'b0 ||
        bus.mem_req_val !== 1'b0 ||
        bus.mem_resp_rdy !== 1'b0) begin
      n_err++;
      $display("FAIL rmid_async got %b/%b/%b want 0/0/0",
               bus.D_val, bus.mem_req_val,
               bus.mem_resp_rdy);
    end
    repeat (2) @(negedge clk);
    bus.D_rdy = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    #1;
    n_vec++;
    if (bus.mem_req_val !== 1'b1 ||
        bus.mem_req_addr !== 32'h200 ||
        bus.D_val !== 1'b0) begin
      n_err++;
      $display("FAIL rmid_restart got %b/%h/%b want 1/00000200/0",
               bus.mem_req_val, bus.mem_req_addr,
               bus.D_val);
    end
    @(negedge clk);
    #1;
    n_vec++;
    if (bus.D_val !== 1'b1 ||
        bus.D_pc !== 32'h200) begin
      n_err++;
      $display("FAIL rmid_d got %b/%h want 1/00000200",
               bus.D_val, bus.D_pc);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    cyc = 0;
    lat = 0;
    rst = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_squash_latency();
    test_squash_resp();
    test_squash_flush();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_unit_basic.md
# fetch_unit_basic

Front-end fetch stage that sits directly upstream of the decode/issue stage. It holds the PC and issues word-aligned instruction requests to memory over a val/rdy interface. It buffers returning instructions in order and presents {inst, pc} to decode over a val/rdy interface. It supports a squash/redirect from later stages, which discards every outstanding and buffered instruction.

## Interface
- p_rst_addr, 32'h0000_0200, PC value loaded on reset
- p_max_in_flight, 2, maximum outstanding requests plus buffered responses (≥1)
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- mem_req_val  out  1  request valid
- mem_req_rdy  in  1  memory accepts request
- mem_req_addr  out  32  fetch address (PC)
- mem_resp_val  in  1  response valid
- mem_resp_rdy  out  1  always 1 after reset; held 0 while rst asserted
- mem_resp_data  in  32  instruction word
- D_val  out  1  instruction valid to decode
- D_rdy  in  1  decode accepts
- D_inst  out  32  instruction word
- D_pc  out  32  PC of D_inst
- squash_val  in  1  redirect request
- squash_target  in  32  new PC (bits [1:0] ignored, treated as 0)

## Operation
- Request fire = mem_req_val & mem_req_rdy.
- Response fire = mem_resp_val (always accepted).
- Output fire = D_val & D_rdy.
- State:
  - pc (32b).
  - in_flight count of requests sent without a response (0..p_max_in_flight).
  - drop count of responses still owed to squashed requests.
  - Response FIFO of depth p_max_in_flight holding {inst, pc}.
  - PC queue of depth p_max_in_flight tracking addresses in flight.
- mem_req_val = !squash_val & (in_flight + drop + fifo_count < p_max_in_flight).
  - This credit rule guarantees FIFO space for every response, so mem_resp_rdy is constant 1.
- On request fire: pc <= pc + 4 (wraps modulo 2^32); push pc into the PC queue; in_flight++.
- On response fire with drop > 0: drop-- and discard the data.
- On response fire with drop == 0: pop the PC queue; push {mem_resp_data, popped pc} into the FIFO; in_flight--.
- D_val = FIFO non-empty; D_inst and D_pc = FIFO head. Output fire pops the FIFO.
- On squash_val:
  - pc <= squash_target & ~3; FIFO and PC queue flushed.
  - drop <= drop + in_flight − (1 if a response fires this cycle, else 0); in_flight <= 0.
  - No request and no output fire this cycle (D_val forced 0).
- Reset: pc = p_rst_addr; in_flight = drop = 0; FIFO and PC queue empty.
  - Reset outputs: mem_req_val = 0, D_val = 0, mem_resp_rdy = 0.
  - Reset mid-transaction: state is lost, and the memory side is also reset.

## Timing
- Request can issue the first cycle after rst deasserts.
- Response to output latency: 1 cycle (response registered into the FIFO; D_val rises the next cycle). There is no combinational path from mem_resp to D_*.
- No combinational path from D_rdy to mem_req_val.
- mem_req_val depends combinationally on squash_val only.
- Simultaneous cases:
  - Output pop and response push in the same cycle are both honoured.
  - squash_val overrides every push, pop and request in that cycle.
- Once asserted, mem_req_val/addr stay stable until the request fires unless squash_val arrives. A squash may withdraw a pending request.
- D_* stay stable while D_val & !D_rdy and no squash.
- Full throughput, one instruction per cycle, requires memory latency < p_max_in_flight cycles.

## Structure
- Shared package (same package as the RV ISA definitions) gains:
  - typedef fetch_msg_t {inst[31:0], pc[31:0]}.
  - Constant for the default reset address.
- Natural sub-module: fetch_fifo, a parametrized depth-N synchronous FIFO with flush.
  - Instantiated twice: once for the PC queue, once for the response FIFO.
- Counters are sized $clog2(p_max_in_flight+1) bits.

## Test plan
- Reset with p_rst_addr=0x200, zero-latency memory, D_rdy=1 -> requests at 0x200, 0x204, 0x208… in consecutive cycles; D_pc follows one cycle behind each response, with no bubbles.
- D_rdy held 0 -> at most p_max_in_flight=2 requests issue; mem_req_val drops to 0. Raising D_rdy -> 0x200 then 0x204 delivered in order, then fetch resumes at 0x208.
- Memory latency 3, two requests in flight, squash_val with target 0x1003 -> next request addr 0x1000; the two stale responses are discarded; first D_pc = 0x1000.
- Squash in the same cycle a response arrives, with in_flight=2 -> drop = 1; exactly one further response is discarded.
- pc = 0xFFFF_FFFC -> next request addr 0x0000_0000.
- rst asserted mid-stream with FIFO non-empty -> D_val and mem_req_val go to 0 immediately (asynchronously); after release, fetch restarts at p_rst_addr.
